// File: rtl/bear_ship_filter_pkg.sv
// ----------------------------------------------------------------------------
// bear_ship_pkg
// Shared types and constants for the bear/ship code filter: code field
// widths, the combined code type, the two FSM states and a packing helper.
// ----------------------------------------------------------------------------
package bear_ship_pkg;

   localparam int BEAR_W = 12;
   localparam int SHIP_W = 8;
   localparam int CODE_W = BEAR_W + SHIP_W;

   typedef logic [CODE_W-1:0] code_t;

   // ACQ hunts for a stable value, LOCK holds while the input stays put
   typedef enum logic {
      ST_ACQ  = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   // Bearing sits in the upper bits so the combined code compares as one word
   function automatic code_t pack_code(input logic [BEAR_W-1:0] bear,
                                       input logic [SHIP_W-1:0] ship);
      pack_code = {bear, ship};
   endfunction

endpackage

// File: rtl/bear_ship_filter_if.sv
// ----------------------------------------------------------------------------
// bear_ship_filter_if
// Valid/ready output channel carrying one accepted bear/ship code.
//   OutValid  producer -> consumer  accepted value pending
//   OutReady  consumer -> producer  consumer takes the value this cycle
//   OutBear   producer -> consumer  accepted bearing code (BEAR_W)
//   OutShip   producer -> consumer  accepted ship code (SHIP_W)
// ----------------------------------------------------------------------------
interface bear_ship_filter_if;
   import bear_ship_pkg::*;

   logic              OutValid;
   logic              OutReady;
   logic [BEAR_W-1:0] OutBear;
   logic [SHIP_W-1:0] OutShip;

   modport master (
      output OutValid,
      output OutBear,
      output OutShip,
      input  OutReady
   );

   modport slave (
      input  OutValid,
      input  OutBear,
      input  OutShip,
      output OutReady
   );

endinterface

// File: rtl/bear_ship_filter_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler 0..DIV-1; Tick is high for the one clock in which
// the count equals DIV-1. Tick is registered and tracks the count exactly.
//   Clk    in   system clock
//   Reset  in   synchronous reset, active-high (count and Tick to 0)
//   Tick   out  one-clock strobe every DIV clocks
// ----------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV = 1024
) (
   input  logic Clk,
   input  logic Reset,
   output logic Tick
);

   localparam int          CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          tick_q;

   // Next count: wrap after the last value
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count and strobe registers; the strobe is loaded from the next count so
   // it is high exactly while the count sits at its last value
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_d == LAST);
      end
   end

   assign Tick = tick_q;

endmodule

// File: rtl/bear_ship_filter.sv
// ----------------------------------------------------------------------------
// bear_ship_filter
// Samples the {Bear,Ship} code from the 74HC165 reader on a slow tick and
// accepts a value only after STABLE_CNT identical consecutive samples. Each
// newly accepted value is offered once on a valid/ready channel.
//   Clk      in   system clock
//   Reset    in   synchronous reset, active-high
//   Bear     in   12-bit bearing code (quasi-static)
//   Ship     in   8-bit ship code (quasi-static)
//   out_if   master side of the valid/ready output channel
//   Stable   out  1 while the FSM is in LOCK
//   Fault    out  input failed to settle for TIMEOUT ticks
//   Overrun  out  one-clock pulse: pending value replaced before it was read
// ----------------------------------------------------------------------------
module bear_ship_filter
   import bear_ship_pkg::*;
#(
   parameter int SAMPLE_DIV = 1024,
   parameter int STABLE_CNT = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [BEAR_W-1:0]   Bear,
   input  logic [SHIP_W-1:0]   Ship,
   bear_ship_filter_if.master  out_if,
   output logic                Stable,
   output logic                Fault,
   output logic                Overrun
);

   localparam int MW = $clog2(STABLE_CNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_CNT);
   localparam logic [MW-1:0] MATCH_PRE = MW'(STABLE_CNT - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

   logic              tick_s;
   code_t             sample_s;
   logic              same_s;
   logic              lock_hit_s;
   logic              accept_s;

   code_t             cand_q,     cand_d;
   logic [MW-1:0]     match_q,    match_d;
   state_e            state_q,    state_d;
   logic [TW-1:0]     to_q,       to_d;
   logic              fault_q,    fault_d;
   logic              have_acc_q, have_acc_d;
   logic              valid_q,    valid_d;
   logic [BEAR_W-1:0] bear_q,     bear_d;
   logic [SHIP_W-1:0] ship_q,     ship_d;
   logic              overrun_q,  overrun_d;

   tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
      .Clk   (Clk),
      .Reset (Reset),
      .Tick  (tick_s)
   );

   // The reader runs on this clock, so its code is used without a synchroniser
   assign sample_s   = pack_code(Bear, Ship);
   assign same_s     = (sample_s == cand_q);
   // This tick brings the match count up to STABLE_CNT
   assign lock_hit_s = tick_s & same_s & (match_q == MATCH_PRE);
   // Re-locking on the value already delivered must not raise a new event
   assign accept_s   = lock_hit_s &
                       (~have_acc_q | (cand_q != pack_code(bear_q, ship_q)));

   // Candidate tracking and saturating match count
   always_comb begin
      cand_d  = cand_q;
      match_d = match_q;
      if (tick_s) begin
         if (!same_s) begin
            cand_d  = sample_s;
            match_d = MW'(1);
         end else if (match_q != MATCH_MAX) begin
            match_d = match_q + MW'(1);
         end else begin
            match_d = match_q;
         end
      end else begin
         match_d = match_q;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACQ: begin
            if (lock_hit_s) begin
               state_d = ST_LOCK;
            end else begin
               state_d = ST_ACQ;
            end
         end
         ST_LOCK: begin
            if (tick_s && !same_s) begin
               state_d = ST_ACQ;
            end else begin
               state_d = ST_LOCK;
            end
         end
         default: state_d = ST_ACQ;
      endcase
   end

   // Timeout counts ACQ ticks only; it is zero in LOCK, on LOCK entry and on
   // the tick that leaves LOCK, and sticks at TIMEOUT rather than wrapping
   always_comb begin
      to_d = to_q;
      if ((state_q == ST_LOCK) || (state_d == ST_LOCK)) begin
         to_d = '0;
      end else if (tick_s && (to_q != TO_MAX)) begin
         to_d = to_q + TW'(1);
      end else begin
         to_d = to_q;
      end
      fault_d = (to_d == TO_MAX);
   end

   // Output channel: load on accept, drop valid on a handshake
   always_comb begin
      valid_d    = valid_q;
      bear_d     = bear_q;
      ship_d     = ship_q;
      have_acc_d = have_acc_q;
      overrun_d  = 1'b0;
      if (accept_s) begin
         {bear_d, ship_d} = cand_q;
         valid_d          = 1'b1;
         have_acc_d       = 1'b1;
         // Overwriting a pending value the consumer is not taking now
         overrun_d        = valid_q & ~out_if.OutReady;
      end else if (valid_q && out_if.OutReady) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Candidate and match count registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cand_q  <= '0;
         match_q <= '0;
      end else begin
         cand_q  <= cand_d;
         match_q <= match_d;
      end
   end

   // FSM state register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_ACQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Timeout counter and fault flag
   always_ff @(posedge Clk) begin
      if (Reset) begin
         to_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         to_q    <= to_d;
         fault_q <= fault_d;
      end
   end

   // Output channel registers and overrun pulse
   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_q    <= 1'b0;
         bear_q     <= '0;
         ship_q     <= '0;
         have_acc_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         bear_q     <= bear_d;
         ship_q     <= ship_d;
         have_acc_q <= have_acc_d;
         overrun_q  <= overrun_d;
      end
   end

   assign out_if.OutValid = valid_q;
   assign out_if.OutBear  = bear_q;
   assign out_if.OutShip  = ship_q;
   assign Stable          = (state_q == ST_LOCK);
   assign Fault           = fault_q;
   assign Overrun         = overrun_q;

endmodule

// File: tb/tb_bear_ship_filter.sv
// ----------------------------------------------------------------------------
// tb_bear_ship_filter
// Directed bench for bear_ship_filter with SAMPLE_DIV=4, STABLE_CNT=3,
// TIMEOUT=8. A local copy of the prescaler phase tells the bench where the
// sample ticks fall; all expected values are written out by hand.
// ----------------------------------------------------------------------------
module tb_bear_ship_filter;
   import bear_ship_pkg::*;

   logic              Clk = 1'b0;
   logic              Reset;
   logic [BEAR_W-1:0] Bear;
   logic [SHIP_W-1:0] Ship;
   logic              Stable;
   logic              Fault;
   logic              Overrun;

   int n_run  = 0;
   int n_fail = 0;
   int ph     = 0;

   bear_ship_filter_if bus ();

   bear_ship_filter #(
      .SAMPLE_DIV (4),
      .STABLE_CNT (3),
      .TIMEOUT    (8)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Bear    (Bear),
      .Ship    (Ship),
      .out_if  (bus.master),
      .Stable  (Stable),
      .Fault   (Fault),
      .Overrun (Overrun)
   );

   always #5 Clk = ~Clk;

   // Prescaler phase: the posedge following a negedge with ph==3 is a tick
   always @(posedge Clk) begin
      if (Reset) ph <= 0;
      else       ph <= (ph == 3) ? 0 : ph + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stop on the negedge just before a tick edge
   task automatic to_pre();
      for (int k = 0; k < 8; k++) begin
         if (ph == 3) break;
         @(negedge Clk);
      end
   endtask

   // Advance past one tick edge, ending on the following negedge
   task automatic tick();
      to_pre();
      @(negedge Clk);
   endtask

   initial begin
      Reset        = 1'b1;
      Bear         = 12'hFFF;
      Ship         = 8'hFF;
      bus.OutReady = 1'b0;

      // 1: reset held 10 clocks, all outputs low
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         chk("rst_valid",   {31'd0, bus.OutValid}, 32'd0);
         chk("rst_bear",    {20'd0, bus.OutBear},  32'd0);
         chk("rst_ship",    {24'd0, bus.OutShip},  32'd0);
         chk("rst_stable",  {31'd0, Stable},       32'd0);
         chk("rst_fault",   {31'd0, Fault},        32'd0);
         chk("rst_overrun", {31'd0, Overrun},      32'd0);
      end
      Reset = 1'b0;
      tick();
      tick();
      chk("rel_no_valid", {31'd0, bus.OutValid}, 32'd0);

      // 2: steady 123/45 accepted one clock after its third tick
      Bear = 12'h123;
      Ship = 8'h45;
      tick();
      tick();
      to_pre();
      chk("acc_pre_valid", {31'd0, bus.OutValid}, 32'd0);
      @(negedge Clk);
      chk("acc_valid",  {31'd0, bus.OutValid}, 32'd1);
      chk("acc_bear",   {20'd0, bus.OutBear},  32'h123);
      chk("acc_ship",   {24'd0, bus.OutShip},  32'h45);
      chk("acc_stable", {31'd0, Stable},       32'd1);
      bus.OutReady = 1'b1;
      @(negedge Clk);
      bus.OutReady = 1'b0;
      chk("hs_clear", {31'd0, bus.OutValid}, 32'd0);
      tick();
      tick();
      tick();
      chk("steady_no_event", {31'd0, bus.OutValid}, 32'd0);
      chk("steady_stable",   {31'd0, Stable},       32'd1);

      // 3: one-tick glitch to 124, then back to 123
      Bear = 12'h124;
      tick();
      chk("glitch_unstable", {31'd0, Stable}, 32'd0);
      Bear = 12'h123;
      tick();
      tick();
      chk("glitch_still_acq", {31'd0, Stable},       32'd0);
      tick();
      chk("glitch_relock",   {31'd0, Stable},       32'd1);
      chk("glitch_no_valid", {31'd0, bus.OutValid}, 32'd0);
      chk("glitch_bear",     {20'd0, bus.OutBear},  32'h123);

      // 4: two accepts without a reader -> overrun
      Bear = 12'h200;
      Ship = 8'h01;
      tick();
      tick();
      tick();
      chk("ovr_first_valid", {31'd0, bus.OutValid}, 32'd1);
      chk("ovr_first_bear",  {20'd0, bus.OutBear},  32'h200);
      chk("ovr_first_none",  {31'd0, Overrun},      32'd0);
      Bear = 12'h300;
      Ship = 8'h02;
      tick();
      tick();
      tick();
      chk("ovr_pulse", {31'd0, Overrun},      32'd1);
      chk("ovr_bear",  {20'd0, bus.OutBear},  32'h300);
      chk("ovr_ship",  {24'd0, bus.OutShip},  32'h02);
      chk("ovr_valid", {31'd0, bus.OutValid}, 32'd1);
      @(negedge Clk);
      chk("ovr_one_clk",  {31'd0, Overrun},      32'd0);
      chk("ovr_held_val", {31'd0, bus.OutValid}, 32'd1);

      // 5: toggling input for 9 ticks -> fault, then settle
      bus.OutReady = 1'b1;
      @(negedge Clk);
      bus.OutReady = 1'b0;
      chk("flt_drain", {31'd0, bus.OutValid}, 32'd0);
      for (int i = 0; i < 9; i++) begin
         Bear = (i % 2 == 0) ? 12'hA00 : 12'hA01;
         tick();
         if (i == 7) chk("flt_not_yet", {31'd0, Fault}, 32'd0);
      end
      chk("flt_set",    {31'd0, Fault},  32'd1);
      chk("flt_stable", {31'd0, Stable}, 32'd0);
      Bear = 12'hBEE;
      Ship = 8'h77;
      tick();
      tick();
      chk("flt_saturated", {31'd0, Fault}, 32'd1);
      tick();
      chk("flt_cleared", {31'd0, Fault},        32'd0);
      chk("flt_lock",    {31'd0, Stable},       32'd1);
      chk("flt_valid",   {31'd0, bus.OutValid}, 32'd1);
      chk("flt_bear",    {20'd0, bus.OutBear},  32'hBEE);
      chk("flt_ship",    {24'd0, bus.OutShip},  32'h77);

      // 6: reset mid-acquire discards the partial match
      Bear = 12'h055;
      Ship = 8'h55;
      tick();
      tick();
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("mid_rst_valid",  {31'd0, bus.OutValid}, 32'd0);
      chk("mid_rst_bear",   {20'd0, bus.OutBear},  32'd0);
      chk("mid_rst_stable", {31'd0, Stable},       32'd0);
      tick();
      tick();
      chk("mid_rst_partial", {31'd0, bus.OutValid}, 32'd0);
      tick();
      chk("mid_rst_acc",  {31'd0, bus.OutValid}, 32'd1);
      chk("mid_rst_bear2", {20'd0, bus.OutBear}, 32'h055);
      Bear = 12'h066;
      Ship = 8'h66;
      tick();
      tick();
      to_pre();
      bus.OutReady = 1'b1;
      chk("same_cyc_pending", {31'd0, bus.OutValid}, 32'd1);
      @(negedge Clk);
      bus.OutReady = 1'b0;
      chk("same_cyc_valid",   {31'd0, bus.OutValid}, 32'd1);
      chk("same_cyc_bear",    {20'd0, bus.OutBear},  32'h066);
      chk("same_cyc_ship",    {24'd0, bus.OutShip},  32'h66);
      chk("same_cyc_no_ovr",  {31'd0, Overrun},      32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
